// File: rtl/timer_seq_ctrl.sv
// Timer sequencer: synchronises clk_int, prescales it and drives load/count_enable/updown to the counter.
// Latency: clk_int rise -> count_enable is 3 gated_clk edges (2-flop sync + registered step); start -> load 1 cycle.
// Backpressure: none; start/stop/int_clr are single-cycle pulses, stop overrides start in the same cycle.
module timer_seq_ctrl #(
    parameter int W     = 32,
    parameter int PSC_W = 8
) (
    input  logic             gated_clk,
    input  logic             preset_n,
    input  logic             clk_int,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_rld,
    input  logic             dir,
    input  logic [PSC_W-1:0] psc,
    input  logic [W-1:0]     cnt,
    input  logic             int_clr,
    output logic             load,
    output logic             count_enable,
    output logic             updown,
    output logic             busy,
    output logic             ovf_irq,
    output logic             udf_irq,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;

    logic              sync1;
    logic              sync2;
    logic              edge_q;
    logic              e;
    logic [PSC_W-1:0]  pcnt;
    logic              step;
    logic              term;
    logic              in_run;
    logic              cnt_evt;
    logic              term_evt;
    logic              arm;
    logic              ce_q;

    // Two-flop synchroniser plus the delayed copy used for rising-edge detection
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= clk_int;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    // One-cycle pulse per synchronised clk_int rising edge
    assign e = sync2 & ~edge_q;

    // A step happens on the edge that completes a full prescale period
    assign step   = e & (pcnt == psc);
    assign in_run = (cur_state == S_RUN);

    // Terminal value depends on the latched direction, not the live dir input
    assign term = updown ? (cnt == '0) : (cnt == '1);

    // Stop suppresses any count or terminal event that would land in the same cycle
    assign cnt_evt  = in_run & step & ~term & ~stop;
    assign term_evt = in_run & step &  term & ~stop;

    // A start is honoured only from IDLE or DONE, and only if stop is not also present
    assign arm = start & ~stop & ((cur_state == S_IDLE) | (cur_state == S_DONE));

    // Prescaler: counts edges only in RUN, forced to zero elsewhere and on stop
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            pcnt <= '0;
        end else if (!in_run || stop) begin
            pcnt <= '0;
        end else if (e) begin
            if (pcnt == psc) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; stop returns to IDLE from anywhere
    always_comb begin
        nxt_state = cur_state;
        if (stop) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE: if (start) nxt_state = S_LOAD;
                S_LOAD: nxt_state = S_RUN;
                S_RUN: begin
                    if (step && term) begin
                        nxt_state = auto_rld ? S_LOAD : S_DONE;
                    end
                end
                S_DONE: if (start) nxt_state = S_LOAD;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Direction is captured only when the timer is armed, so dir changes mid-run are ignored
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            updown <= 1'b0;
        end else if (arm) begin
            updown <= dir;
        end
    end

    // Registered count strobe keeps count_enable glitch-free towards the counter
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            ce_q <= 1'b0;
        end else begin
            ce_q <= cnt_evt;
        end
    end

    // Sticky interrupt flags; a new terminal event wins over int_clr in the same cycle
    always_ff @(posedge gated_clk or negedge preset_n) begin
        if (!preset_n) begin
            ovf_irq <= 1'b0;
            udf_irq <= 1'b0;
        end else begin
            ovf_irq <= (term_evt & ~updown) | (ovf_irq & ~int_clr);
            udf_irq <= (term_evt &  updown) | (udf_irq & ~int_clr);
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        load = 1'b0;
        busy = 1'b0;
        case (cur_state)
            S_LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            S_RUN: begin
                busy = 1'b1;
            end
            default: begin
                load = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    assign count_enable = ce_q;
    assign state        = cur_state;

endmodule
